pipelined_addsub: RTL and testbench



---
 rtl/pipelined_addsub_pkg.sv | 21 ++
 rtl/pipelined_addsub_ripple_chunk.sv | 44 ++++
 rtl/pipelined_addsub.sv | 115 +++++++++++
 tb/tb_pipelined_addsub.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared types for the pipelined add/sub datapath.
// Holds the op encoding and the per-stage register bundle.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest datapath a stage bundle can carry.
  localparam int ADDSUB_MAXW = 64;

  typedef struct packed {
    logic                   valid;
    logic                   sub;
    logic [ADDSUB_MAXW-1:0] psum;
    logic [ADDSUB_MAXW-1:0] a;
    logic [ADDSUB_MAXW-1:0] b;
    logic                   carry;
    logic                   ovf;
  } stage_t;

endpackage

// File: rtl/pipelined_addsub_ripple_chunk.sv
// CHUNK-bit ripple-carry slice built from a full-adder cell.
// Also exposes the carry into its MSB for overflow detection.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module ripple_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[CHUNK];
  assign cm = c[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits per stage.
// Carry is registered between stages; whole pipe stalls on backpressure.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0 || WIDTH > ADDSUB_MAXW
      || CHUNK < 1) begin : g_bad_cfg
    $error("pipelined_addsub: bad WIDTH/CHUNK");
  end

  stage_t head;
  stage_t src [STAGES];
  stage_t nxt [STAGES];
  stage_t q   [STAGES];
  logic   stall;
  logic   unused_last;

  function automatic stage_t step(
    input stage_t           si,
    input logic [CHUNK-1:0] s,
    input logic             co,
    input logic             cm,
    input int               k
  );
    stage_t r;
    r = si;
    r.psum[k*CHUNK +: CHUNK] = s;
    r.carry = co;
    r.ovf   = co ^ cm;
    return r;
  endfunction

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Stage-0 operand prep: invert b and cin for subtraction.
  always_comb begin
    head = '0;
    head.valid = in_valid;
    head.sub   = sub;
    head.a[WIDTH-1:0] = a;
    head.b[WIDTH-1:0] = (sub == OP_ADD) ? b : ~b;
    head.carry = (sub == OP_SUB) ? ~cin : cin;
  end

  // Each stage consumes the previous stage's register.
  always_comb begin
    src[0] = head;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] s;
    logic             co;
    logic             cm;

    ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a  (src[k].a[k*CHUNK +: CHUNK]),
      .b  (src[k].b[k*CHUNK +: CHUNK]),
      .ci (src[k].carry),
      .s  (s),
      .co (co),
      .cm (cm)
    );

    assign nxt[k] = step(src[k], s, co, cm, k);
  end

  // Advance all stages together; bubbles keep their stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        q[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        if (nxt[k].valid) begin
          q[k] <= nxt[k];
        end else begin
          q[k].valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = q[STAGES-1].valid;
  assign sum       = q[STAGES-1].psum[WIDTH-1:0];
  assign cout      = q[STAGES-1].carry ^ q[STAGES-1].sub;
  assign ovf       = q[STAGES-1].ovf;

  assign unused_last = ^q[STAGES-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub (CHUNK=4 and CHUNK=16 instances).
// Random and directed beats checked against an arithmetic model.
module tb_pipelined_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic        in_ready1;
  logic        out_valid1;
  logic [15:0] sum1;
  logic        cout1;
  logic        ovf1;

  int errors = 0;
  int checks = 0;

  logic [17:0] q  [$];
  logic [17:0] q1 [$];

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  pipelined_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid1),
    .out_ready (1'b1),
    .sum       (sum1),
    .cout      (cout1),
    .ovf       (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout, ovf, sum} from integer arithmetic.
  function automatic logic [17:0] ref_op(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c,
    input logic        s
  );
    int          sx;
    int          sy;
    int          r;
    int unsigned u;
    logic        co;
    logic        ov;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      u  = 32'(x) + 32'(y) + 32'(c);
      co = (u > 32'd65535);
      r  = sx + sy + int'(c);
    end else begin
      u  = 32'(x) - 32'(y) - 32'(c);
      co = (32'(x) < 32'(y) + 32'(c));
      r  = sx - sy - int'(c);
    end
    ov = (r > 32767) || (r < -32768);
    return {co, ov, u[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) tick();
    checks++;
    if ({out_valid, cout, ovf, sum} !== 19'd0) begin
      errors++;
      $display("FAIL reset_out got=%h exp=0",
               {out_valid, cout, ovf, sum});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_out1 got=%b exp=0", out_valid1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vector(
    input string       nm,
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c,
    input logic        s,
    input logic [15:0] es,
    input logic        ec,
    input logic        eo
  );
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = x; b = y; cin = c; sub = s;
    tick();
    n = 1;
    in_valid = 1'b0;
    checks++;
    if (!(out_valid1 === 1'b1 && {cout1, ovf1, sum1} === {ec, eo, es})) begin
      errors++;
      $display("FAIL %s_chunk16 got=%b/%h exp=1/%h",
               nm, out_valid1, {cout1, ovf1, sum1}, {ec, eo, es});
    end
    while (out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL %s_latency got=%0d exp=4", nm, n);
    end
    checks++;
    if ({cout, ovf, sum} !== {ec, eo, es}) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, {cout, ovf, sum}, {ec, eo, es});
    end
    tick();
  endtask

  task automatic test_directed();
    test_vector("add_basic", 16'h1234, 16'h0FF0, 1'b0, 1'b0,
                16'h2224, 1'b0, 1'b0);
    test_vector("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0,
                16'h8000, 1'b0, 1'b1);
    test_vector("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0,
                16'h0000, 1'b1, 1'b0);
    test_vector("sub_wrap",  16'h0000, 16'h0001, 1'b0, 1'b1,
                16'hFFFF, 1'b1, 1'b0);
    test_vector("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1,
                16'h7FFE, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    int sent = 0;
    int got = 0;
    int got1 = 0;
    int first = -1;
    int first1 = -1;
    int last = -1;
    int cyc = 0;
    q.delete();
    q1.delete();
    out_ready = 1'b1;
    while ((got < 20 || got1 < 20) && cyc < 60) begin
      if (sent < 20) begin
        in_valid = 1'b1;
        rand_beat();
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        e = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        if ({cout, ovf, sum} !== e) begin
          errors++;
          $display("FAIL b2b[%0d] got=%h exp=%h", got, {cout, ovf, sum}, e);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (out_valid1) begin
        checks++;
        e = (q1.size() > 0) ? q1.pop_front() : 18'h3FFFF;
        if ({cout1, ovf1, sum1} !== e) begin
          errors++;
          $display("FAIL b2b16[%0d] got=%h exp=%h",
                   got1, {cout1, ovf1, sum1}, e);
        end
        if (first1 < 0) first1 = cyc;
        got1++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_op(a, b, cin, sub));
        sent++;
      end
      if (in_valid && in_ready1) q1.push_back(ref_op(a, b, cin, sub));
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 20 || got1 !== 20) begin
      errors++;
      $display("FAIL b2b_count got=%0d/%0d exp=20/20", got, got1);
    end
    checks++;
    if (first !== 4 || first1 !== 1) begin
      errors++;
      $display("FAIL b2b_latency got=%0d/%0d exp=4/1", first, first1);
    end
    checks++;
    if (last - first !== 19) begin
      errors++;
      $display("FAIL b2b_throughput got=%0d exp=19", last - first);
    end
  endtask

  task automatic test_stall();
    logic [17:0] e;
    logic [17:0] held;
    int acc = 0;
    int got = 0;
    int n = 0;
    q.delete();
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && n < 20) begin
      in_valid = 1'b1;
      rand_beat();
      if (in_ready) begin
        q.push_back(ref_op(a, b, cin, sub));
        acc++;
      end
      tick();
      n++;
    end
    checks++;
    if (acc !== 4 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_fill got=%0d/%b exp=4/1", acc, out_valid);
    end
    held = {cout, ovf, sum};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      rand_beat();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1
          || {cout, ovf, sum} !== held) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=%b/%b/%h exp=0/1/%h",
                 i, in_ready, out_valid, {cout, ovf, sum}, held);
      end
      if (in_ready) q.push_back(ref_op(a, b, cin, sub));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (n < 20) begin
      if (out_valid) begin
        checks++;
        e = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        if ({cout, ovf, sum} !== e) begin
          errors++;
          $display("FAIL drain[%0d] got=%h exp=%h", got, {cout, ovf, sum}, e);
        end
        got++;
      end
      tick();
      n++;
    end
    checks++;
    if (got !== 4 || q.size() !== 0) begin
      errors++;
      $display("FAIL drain_count got=%0d left=%0d exp=4/0", got, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_beat();
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got=%b exp=1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, cout, ovf, sum, out_valid1} !== 20'd0) begin
      errors++;
      $display("FAIL mid_async got=%h exp=0",
               {out_valid, cout, ovf, sum, out_valid1});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_ready got=%b exp=1", in_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || out_valid1) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL mid_stale got=%0d exp=0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
